// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory request/response channel, redirect input
// and the decode-side valid/ready queue head.
interface fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_pc;
  logic [31:0]     dec_instr;

  modport master (
    output imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, dec_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, keeps one imem request in flight, and queues
// {pc, instr} pairs for decode; redirects flush the queue and drop stale responses.
//
// state | meaning
// REQ   | may issue a request
// WAIT  | one request outstanding, its response will be queued
// DROP  | one request outstanding, its response will be discarded
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              QDEPTH   = 2
) (
  input  logic            clk,
  input  logic            reset,
  fetch_if.master         bus,
  output logic [XLEN-1:0] pc
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DROP = 2'd2;

  localparam int PW = 2;
  localparam int CW = 3;
  localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);

  logic [1:0]      state;
  logic [XLEN-1:0] req_pc;

  // Storage is sized for the largest QDEPTH; pointers wrap at QDEPTH.
  logic [XLEN-1:0] q_pc    [4];
  logic [31:0]     q_instr [4];
  logic [PW-1:0]   head, tail, head_nxt;
  logic [CW-1:0]   count, count_after_pop, count_nxt;

  logic flush, req_fire, push, pop;
  logic [XLEN-1:0] dec_pc_q;
  logic [31:0]     dec_instr_q;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign flush              = bus.redirect_valid;
  assign bus.dec_valid      = (count != '0);
  assign bus.dec_pc         = dec_pc_q;
  assign bus.dec_instr      = dec_instr_q;
  assign bus.imem_req_addr  = pc;
  // Gated by reset so the request stays low while reset is held.
  assign bus.imem_req_valid = reset && (state == S_REQ) && (count < DEPTH) && !flush;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign push     = (state == S_WAIT) && bus.imem_rsp_valid && !flush;
  assign pop      = bus.dec_valid && bus.dec_ready && !flush;

  assign head_nxt        = pop ? inc(head) : head;
  assign count_after_pop = count - CW'(pop);
  assign count_nxt       = flush ? '0 : count_after_pop + CW'(push);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_REQ;
    end else begin
      case (state)
        S_REQ:   if (req_fire) state <= S_WAIT;
        S_WAIT:  if (bus.imem_rsp_valid) state <= S_REQ;
                 else if (flush) state <= S_DROP;
        S_DROP:  if (bus.imem_rsp_valid) state <= S_REQ;
        default: state <= S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      if (flush)         pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      else if (req_fire) pc <= pc + XLEN'(4);
      if (req_fire) req_pc <= pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      count <= count_nxt;
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        head <= head_nxt;
        if (push) tail <= inc(tail);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[tail]    <= req_pc;
      q_instr[tail] <= bus.imem_rsp_data;
    end
  end

  // Head registers load the entry that will be at the head next cycle and
  // otherwise hold, so an empty queue keeps showing the last instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_pc_q    <= '0;
      dec_instr_q <= '0;
    end else if (!flush && count_nxt != '0) begin
      if (count_after_pop == '0) begin
        dec_pc_q    <= req_pc;
        dec_instr_q <= bus.imem_rsp_data;
      end else begin
        dec_pc_q    <= q_pc[head_nxt];
        dec_instr_q <= q_instr[head_nxt];
      end
    end
  end

  stray_rsp: assert property (@(posedge clk) disable iff (!reset)
    !(state == S_REQ && bus.imem_rsp_valid));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: ordering, back-pressure, redirects in each
// state, PC wrap and mid-run reset, with a cycle-accurate imem stub.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] pc;
  int          errors = 0;
  int          checks = 0;
  logic        auto_mem;
  logic        pend;
  logic [31:0] paddr;

  fetch_if #(.XLEN(32)) bus ();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .QDEPTH(2)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.master),
    .pc    (pc)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0050_0093;
      32'h8:   return 32'h00A0_0113;
      default: return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: remember whether a request is being accepted, then after the
  // edge drop one-shot inputs and, in auto mode, return the 1-cycle response.
  task automatic cycle();
    pend  = bus.imem_req_valid && bus.imem_req_ready;
    paddr = bus.imem_req_addr;
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    bus.imem_rsp_valid = auto_mem && pend;
    bus.imem_rsp_data  = (auto_mem && pend) ? mem_word(paddr) : 32'h0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    logic [31:0] exp_instr [3];
    exp_instr[0] = 32'h0000_0013;
    exp_instr[1] = 32'h0050_0093;
    exp_instr[2] = 32'h00A0_0113;

    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 1'b1;
    auto_mem = 1'b1;
    pend     = 1'b0;
    paddr    = '0;

    // reset state
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_dec_valid", bus.dec_valid, 0);
    chk("rst_dec_pc", bus.dec_pc, 0);
    chk("rst_dec_instr", bus.dec_instr, 0);
    chk("rst_pc", pc, 0);

    // in-order fetch with a 1-cycle memory
    rst_n = 1'b1;
    #1;
    chk("t1_req_valid", bus.imem_req_valid, 1);
    chk("t1_req_addr", bus.imem_req_addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t1_dec_valid_rsp_cycle", bus.dec_valid, 0);
      cycle();
      chk("t1_dec_valid", bus.dec_valid, 1);
      chk("t1_dec_pc", bus.dec_pc, 32'(i * 4));
      chk("t1_dec_instr", bus.dec_instr, exp_instr[i]);
    end

    // back-pressure fills the queue, then drains
    bus.dec_ready = 1'b0;
    do_reset();
    cycle();
    cycle();
    chk("t2_req_valid_2nd", bus.imem_req_valid, 1);
    chk("t2_req_addr_2nd", bus.imem_req_addr, 32'h4);
    cycle();
    cycle();
    chk("t2_full_req_valid", bus.imem_req_valid, 0);
    chk("t2_full_pc", pc, 32'h8);
    chk("t2_full_dec_pc", bus.dec_pc, 32'h0);
    repeat (3) cycle();
    chk("t2_hold_req_valid", bus.imem_req_valid, 0);
    chk("t2_hold_pc", pc, 32'h8);
    bus.dec_ready = 1'b1;
    #1;
    cycle();
    chk("t2_drain_dec_pc", bus.dec_pc, 32'h4);
    chk("t2_resume_req_valid", bus.imem_req_valid, 1);
    chk("t2_resume_addr", bus.imem_req_addr, 32'h8);
    cycle();
    chk("t2_empty_dec_valid", bus.dec_valid, 0);
    cycle();
    chk("t2_dec_pc_8", bus.dec_pc, 32'h8);
    chk("t2_dec_instr_8", bus.dec_instr, 32'h00A0_0113);

    // redirect with two queued entries, nothing outstanding
    bus.dec_ready = 1'b0;
    do_reset();
    repeat (4) cycle();
    chk("t3_pre_full", bus.imem_req_valid, 0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    bus.dec_ready      = 1'b1;
    #1;
    chk("t3_no_req_in_redirect", bus.imem_req_valid, 0);
    cycle();
    chk("t3_flush_dec_valid", bus.dec_valid, 0);
    chk("t3_pc", pc, 32'h100);
    chk("t3_req_valid", bus.imem_req_valid, 1);
    chk("t3_req_addr", bus.imem_req_addr, 32'h100);
    cycle();
    cycle();
    chk("t3_dec_valid", bus.dec_valid, 1);
    chk("t3_dec_pc", bus.dec_pc, 32'h100);
    chk("t3_dec_instr", bus.dec_instr, 32'h5A5A_0100);

    // redirect while a request to 0x8 is in flight
    auto_mem      = 1'b0;
    bus.dec_ready = 1'b1;
    do_reset();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8;
    #1;
    cycle();
    chk("t4_req_addr_8", bus.imem_req_addr, 32'h8);
    chk("t4_req_valid_8", bus.imem_req_valid, 1);
    cycle();
    chk("t4_wait_req_valid", bus.imem_req_valid, 0);
    chk("t4_wait_pc", pc, 32'hC);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    #1;
    chk("t4_redirect_req_valid", bus.imem_req_valid, 0);
    cycle();
    chk("t4_drop_pc", pc, 32'h200);
    chk("t4_drop_req_valid", bus.imem_req_valid, 0);
    cycle();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hDEAD_0008;
    #1;
    chk("t4_rsp_cycle_req_valid", bus.imem_req_valid, 0);
    cycle();
    chk("t4_discard_dec_valid", bus.dec_valid, 0);
    chk("t4_req_valid_200", bus.imem_req_valid, 1);
    chk("t4_req_addr_200", bus.imem_req_addr, 32'h200);
    cycle();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'h1357_2468;
    #1;
    cycle();
    chk("t4_dec_pc", bus.dec_pc, 32'h200);
    chk("t4_dec_instr", bus.dec_instr, 32'h1357_2468);
    chk("t4_pc", pc, 32'h204);

    // redirect coincides with a response; unaligned target
    cycle();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBAD0_0204;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h303;
    #1;
    chk("t5_redirect_req_valid", bus.imem_req_valid, 0);
    cycle();
    chk("t5_no_push", bus.dec_valid, 0);
    chk("t5_pc_aligned", pc, 32'h300);
    chk("t5_req_valid", bus.imem_req_valid, 1);
    chk("t5_req_addr", bus.imem_req_addr, 32'h300);
    chk("t5_dec_pc_held", bus.dec_pc, 32'h200);

    // PC wrap, then reset while waiting on a response
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    auto_mem = 1'b1;
    #1;
    cycle();
    chk("t6_req_addr_top", bus.imem_req_addr, 32'hFFFF_FFFC);
    chk("t6_req_valid_top", bus.imem_req_valid, 1);
    cycle();
    chk("t6_pc_wrap", pc, 32'h0);
    cycle();
    chk("t6_dec_pc_top", bus.dec_pc, 32'hFFFF_FFFC);
    chk("t6_dec_instr_top", bus.dec_instr, 32'hA5A5_FFFC);
    chk("t6_req_addr_0", bus.imem_req_addr, 32'h0);
    chk("t6_req_valid_0", bus.imem_req_valid, 1);
    cycle();
    rst_n = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    auto_mem = 1'b0;
    #1;
    chk("t6_rst_req_valid", bus.imem_req_valid, 0);
    chk("t6_rst_dec_valid", bus.dec_valid, 0);
    chk("t6_rst_dec_pc", bus.dec_pc, 0);
    chk("t6_rst_dec_instr", bus.dec_instr, 0);
    chk("t6_rst_pc", pc, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
    chk("t6_post_rst_req_valid", bus.imem_req_valid, 1);
    chk("t6_post_rst_req_addr", bus.imem_req_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that owns the program counter and produces the fetched stream consumed by the decode stage.
- Issues word-aligned requests to the instruction memory over a valid/ready request channel and receives in-order responses.
- Buffers fetched {pc, instr} pairs in a small queue that feeds decode through a valid/ready handshake.
- Applies branch/jump redirects: flushes the queue and discards any stale in-flight response.

Parameters:
- XLEN, 32: address/PC width.
- RESET_PC, 0: PC value loaded on reset.
- QDEPTH, 2: fetch queue entries, range 2..4.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low reset.
- imem_req_valid, output, 1: fetch request valid.
- imem_req_ready, input, 1: memory accepts request.
- imem_req_addr, output, XLEN: fetch address, equals pc.
- imem_rsp_valid, input, 1: response valid, single cycle, in order.
- imem_rsp_data, input, 32: instruction word.
- redirect_valid, input, 1: branch/jump taken, single cycle.
- redirect_pc, input, XLEN: redirect target.
- dec_valid, output, 1: queue head valid.
- dec_ready, input, 1: decode consumes head.
- dec_pc, output, XLEN: PC of head instruction.
- dec_instr, output, 32: head instruction.
- pc, output, XLEN: current fetch PC register.

Behaviour:
- **Reset (reset low, async):**
  - pc = RESET_PC, queue empty, state = REQ, outstanding = 0.
  - imem_req_valid = 0, dec_valid = 0, dec_pc = 0, dec_instr = 0.
- **FSM states:**
  - REQ: may issue a request.
  - WAIT: one request outstanding.
  - DROP: outstanding response is to be discarded.
- **Request rule:**
  - Condition: imem_req_valid = (state==REQ) && (count < QDEPTH) && !redirect_valid.
  - imem_req_addr = pc.
  - The imem protocol permits withdrawal of an unaccepted request.
- **Request accept (valid && ready):**
  - pc <= pc+4, modulo 2^XLEN, so 0xFFFFFFFC wraps to 0.
  - Latch the request PC, state <= WAIT.
- **At most one outstanding request.** Slot reservation: a request is issued only if count < QDEPTH, so a response never finds the queue full.
- **WAIT + imem_rsp_valid (no redirect):**
  - Push {latched PC, imem_rsp_data}.
  - state <= REQ.
  - dec_valid rises the following cycle if the queue was empty.
- **Queue:**
  - Registered FIFO; dec_* driven from the head entry.
  - Pop on dec_valid && dec_ready.
  - Simultaneous push and pop are allowed at any occupancy, and count is unchanged.
  - When empty, dec_pc and dec_instr hold their last values.
- **Latency:**
  - Request accepted in cycle N, response in cycle M ≥ N+1, dec_valid high in M+1 (for an empty queue).
  - Back-to-back throughput: one instruction per 2 cycles minimum with a 1-cycle memory.
- **Redirect (redirect_valid high in cycle R):**
  - pc <= {redirect_pc[XLEN-1:2], 2'b00}; low bits are forced to zero.
  - Queue flushed, so dec_valid = 0 from R+1.
  - A pop in cycle R is ignored.
  - No request is issued in cycle R.
- **Redirect state transitions:**
  - REQ: stay REQ.
  - WAIT without rsp_valid in cycle R: go to DROP.
  - WAIT with rsp_valid in cycle R: discard the response, go to REQ.
  - DROP: stay DROP, or go to REQ if rsp_valid arrives in cycle R; pc takes the latest target.
- **DROP + imem_rsp_valid:** discard the data (no push), state <= REQ.
- **Back-pressure:**
  - dec_ready low indefinitely: the queue fills and the fetch halts with imem_req_valid = 0.
  - pc stays pointing at the next unfetched address.
- **Reset assertion mid-operation:** clears all state immediately; any memory response arriving after reset release without a request is ignored.
- **Response without outstanding request** (state REQ): ignored. A verification assertion flags this case.

Test Plan:
- **Reset release, 1-cycle memory, dec_ready=1:**
  - First request at addr 0x0.
  - Instructions 0x00000013 at pc 0x0, 0x00500093 at pc 0x4, 0x00A00113 at pc 0x8 appear in order.
  - Each dec_valid is high 1 cycle after its response.
- **dec_ready=0 with a 1-cycle memory:**
  - Exactly QDEPTH=2 requests are issued (0x0, 0x4), then imem_req_valid stays 0 and pc=0x8.
  - Raising dec_ready drains 0x0 then 0x4, and fetch resumes at 0x8.
- **Redirect with the queue holding 2 entries and none outstanding (redirect_pc=0x100):**
  - dec_valid=0 next cycle.
  - Next request addr 0x100; next dec_pc = 0x100.
- **Redirect to 0x200 while a request to 0x8 is in flight (response 3 cycles later):**
  - The response for 0x8 is discarded.
  - The next request addr is 0x200 and is issued only after that response.
- **Redirect cycle coincides with imem_rsp_valid, and redirect_pc=0x303:**
  - The response is not pushed.
  - pc=0x300; next request 0x300 in the following cycle.
- **Wrap and reset mid-run:**
  - redirect_pc=0xFFFFFFFC: fetch 0xFFFFFFFC then 0x00000000.
  - Assert reset while in WAIT: outputs clear immediately; after release, the first request is at RESET_PC.
